// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//
// Playback engine for the note highway. It walks the song note store one
// index per beat and captures the 5-lane note word that comes back. Each
// captured word enters row 0 of a ROWS-deep shift register (the "highway")
// and moves one row per beat. The oldest row (ROWS-1) is the strike row that
// the scoring logic judges against.
//
// Parameters
//   BEAT_DIV  : clock cycles per beat (>= 4, so go settles before capture)
//   ROWS      : highway depth in rows (2..32)
//   END_INDEX : last valid note index (<= 127)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   level request; honoured only in IDLE or DONE
//   pause        in   freezes the beat counter and the state while high
//   go           out  7-bit note index to the note store
//   data         in   5-bit note word, valid two edges after go changes
//   highway      out  row r at bits [5r+4:5r]; row 0 newest
//   strike_notes out  copy of highway row ROWS-1
//   strike_valid out  one-cycle pulse when a nonzero word enters the strike row
//   beat_tick    out  one-cycle pulse following each beat
//   playing      out  high in PLAY and DRAIN
//   done         out  high in DONE
//
// Build option
//   NOTE_SEQ_LOOP_EN : when defined the song wraps from END_INDEX back to 0
//                      and stays in PLAY forever (no DRAIN/DONE). When not
//                      defined the song drains ROWS empty beats and stops.
// ---------------------------------------------------------------------------
module note_sequencer #(
  parameter int BEAT_DIV  = 25_000_000,
  parameter int ROWS      = 8,
  parameter int END_INDEX = 93
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  output logic [6:0]        go,
  input  logic [4:0]        data,
  output logic [5*ROWS-1:0] highway,
  output logic [4:0]        strike_notes,
  output logic              strike_valid,
  output logic              beat_tick,
  output logic              playing,
  output logic              done
);

  localparam int CW  = $clog2(BEAT_DIV);
  localparam int DW  = $clog2(ROWS);
  localparam int TOP = 5 * (ROWS - 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(BEAT_DIV - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ROWS - 1);
  localparam logic [6:0]    GO_LAST    = 7'(END_INDEX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [6:0]         go_q, go_d;
  logic [5*ROWS-1:0]  highway_q, highway_d;
  logic               beat_tick_q, beat_tick_d;
  logic               strike_valid_q, strike_valid_d;

  // Highway contents after one beat: every row moves one step towards the
  // strike row and row 0 takes the new word (zeros while draining).
  logic [4:0]         fill_word;
  logic [5*ROWS-1:0]  shifted;

  assign fill_word    = (state_q == S_DRAIN) ? 5'b00000 : data;
  assign shifted[4:0] = fill_word;

  genvar gi;
  generate
    for (gi = 1; gi < ROWS; gi++) begin : g_shift
      assign shifted[5*gi +: 5] = highway_q[5*(gi-1) +: 5];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      drain_q        <= '0;
      go_q           <= '0;
      highway_q      <= '0;
      beat_tick_q    <= 1'b0;
      strike_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      drain_q        <= drain_d;
      go_q           <= go_d;
      highway_q      <= highway_d;
      beat_tick_q    <= beat_tick_d;
      strike_valid_q <= strike_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    drain_d        = drain_q;
    go_d           = go_q;
    highway_d      = highway_q;
    beat_tick_d    = 1'b0;
    strike_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        go_d  = '0;
        if (start) begin
          state_d   = S_PLAY;
          highway_d = '0;
        end
      end

      S_PLAY, S_DRAIN: begin
        // Pause freezes everything, including the counter, so the beat that
        // would have fired simply waits for the first unpaused edge.
        if (!pause) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d          = '0;
            highway_d      = shifted;
            beat_tick_d    = 1'b1;
            strike_valid_d = (shifted[TOP +: 5] != 5'b00000);

            if (state_q == S_PLAY) begin
              if (go_q == GO_LAST) begin
`ifdef NOTE_SEQ_LOOP_EN
                go_d = '0;
`else
                // go stays parked on the last index while draining.
                state_d = S_DRAIN;
                drain_d = '0;
`endif
              end else begin
                go_d = go_q + 7'd1;
              end
            end else begin
              // ROWS empty beats flush every note past the strike row.
              if (drain_q == DRAIN_LAST) begin
                state_d = S_DONE;
              end else begin
                drain_d = drain_q + DW'(1);
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_DONE: begin
        cnt_d = '0;
        if (start) begin
          state_d   = S_PLAY;
          go_d      = '0;
          highway_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign go           = go_q;
  assign highway      = highway_q;
  assign strike_notes = highway_q[TOP +: 5];
  assign strike_valid = strike_valid_q;
  assign beat_tick    = beat_tick_q;
  assign playing      = (state_q == S_PLAY) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
//
// Drives note_sequencer with directed and randomized start/pause sequences
// and compares every output after every clock edge against a reference
// model. The model describes playback purely in terms of how many unpaused
// cycles have elapsed since the song started: the number of beats k is that
// count divided by BEAT_DIV, and every output (go, highway rows, strike row,
// pulses, playing/done) is a direct function of k and the song contents.
// ---------------------------------------------------------------------------
module tb_note_sequencer;

  localparam int BD    = 4;
  localparam int RW    = 4;
  localparam int EI    = 3;
  localparam int TOTAL = EI + 1 + RW;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            pause = 1'b0;
  logic [6:0]      go;
  logic [4:0]      data  = 5'd0;
  logic [4:0]      d1    = 5'd0;
  logic [5*RW-1:0] highway;
  logic [4:0]      strike_notes;
  logic            strike_valid;
  logic            beat_tick;
  logic            playing;
  logic            done;

  logic [4:0]      mem [0:127];

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_running  = 1'b0;
  bit m_finished = 1'b0;
  bit m_tick     = 1'b0;
  int m_n        = 0;   // unpaused cycles since the start-accept edge
  int m_k        = 0;   // beats completed in the current run

  note_sequencer #(
    .BEAT_DIV  (BD),
    .ROWS      (RW),
    .END_INDEX (EI)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pause        (pause),
    .go           (go),
    .data         (data),
    .highway      (highway),
    .strike_notes (strike_notes),
    .strike_valid (strike_valid),
    .beat_tick    (beat_tick),
    .playing      (playing),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Note store: registered read, word appears two edges after go changes.
  always @(posedge clk) begin
    d1   <= mem[go];
    data <= d1;
  end

  // Word captured on beat j (1-based) of the current run.
  function automatic logic [4:0] cap(input int j);
    if (j < 1) return 5'd0;
`ifdef NOTE_SEQ_LOOP_EN
    return mem[(j - 1) % (EI + 1)];
`else
    if (j <= EI + 1) return mem[j - 1];
    return 5'd0;
`endif
  endfunction

  function automatic logic [6:0] exp_go();
`ifdef NOTE_SEQ_LOOP_EN
    return 7'(m_k % (EI + 1));
`else
    return 7'((m_k > EI) ? EI : m_k);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [5*RW-1:0] eh;
    logic [4:0]      es;
    for (int r = 0; r < RW; r++) eh[5*r +: 5] = cap(m_k - r);
    es = cap(m_k - (RW - 1));
    chk("go",           64'(go),           64'(exp_go()));
    chk("highway",      64'(highway),      64'(eh));
    chk("strike_notes", 64'(strike_notes), 64'(es));
    chk("beat_tick",    64'(beat_tick),    64'(m_tick));
    chk("strike_valid", 64'(strike_valid), 64'(m_tick && (es != 5'd0)));
    chk("playing",      64'(playing),      64'(m_running));
    chk("done",         64'(done),         64'(m_finished));
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input bit s, input bit p);
    m_tick = 1'b0;
    if (m_running) begin
      if (!p) begin
        m_n++;
        if (m_n % BD == 0) begin
          m_k    = m_n / BD;
          m_tick = 1'b1;
`ifndef NOTE_SEQ_LOOP_EN
          if (m_k == TOTAL) begin
            m_running  = 1'b0;
            m_finished = 1'b1;
          end
`endif
        end
      end
    end else if (s) begin
      m_running  = 1'b1;
      m_finished = 1'b0;
      m_n        = 0;
      m_k        = 0;
    end
  endtask

  task automatic step(input bit s, input bit p);
    start = s;
    pause = p;
    @(posedge clk);
    model_edge(s, p);
    #1;
    check_all();
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    m_running  = 1'b0;
    m_finished = 1'b0;
    m_tick     = 1'b0;
    m_n        = 0;
    m_k        = 0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic randomize_song();
    for (int i = 0; i < 128; i++) mem[i] = 5'($urandom);
  endtask

  initial begin
    int cnt;

    randomize_song();
    mem[0] = 5'b00001;
    mem[1] = 5'b00001;
    mem[2] = 5'b00100;
    mem[3] = 5'b10000;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset: outputs checked");

    // Idle: pause has no effect
    step(0, 0);
    step(0, 1);
    step(0, 0);
    $display("[TB] idle: held with pause toggled");

    // Directed song from the reference word table
    step(1, 0);
    repeat (39) step(0, 0);
    $display("[TB] directed song: go=%0d playing=%0b done=%0b", go, playing, done);

`ifndef NOTE_SEQ_LOOP_EN
    // Start from DONE and measure the full song length
    step(1, 0);
    cnt = 0;
    while (!done && cnt < 200) begin
      step(0, 0);
      cnt++;
    end
    chk("done_latency", 64'(cnt), 64'(BD * TOTAL));
    $display("[TB] restart from done: %0d cycles to done", cnt);
`else
    repeat (40) step(0, 0);
    $display("[TB] loop run: done=%0b after 40 more cycles", done);
`endif

    // Pause held 10 cycles early in the first beat
    async_reset();
    step(1, 0);
    step(0, 0);
    repeat (10) step(0, 1);
    repeat (20) step(0, 0);
    $display("[TB] pause early in beat: go=%0d", go);

    // Pause asserted exactly on the would-be tick edge
    async_reset();
    step(1, 0);
    repeat (3) step(0, 0);
    step(0, 1);
    step(0, 1);
    repeat (6) step(0, 0);
    $display("[TB] pause on tick edge: go=%0d", go);

    // start pulsed while playing is ignored
    async_reset();
    step(1, 0);
    repeat (5) step(0, 0);
    step(1, 0);
    repeat (10) step(0, 0);
    $display("[TB] start during play: go=%0d", go);

    // Reset mid-play, then replay from index 0
    async_reset();
    step(1, 0);
    repeat (7) step(0, 0);
    async_reset();
    step(0, 0);
    step(1, 0);
    repeat (10) step(0, 0);
    $display("[TB] reset mid-play and replay: go=%0d", go);

    // Randomized start/pause traffic with fresh song contents
    for (int round = 0; round < 3; round++) begin
      async_reset();
      randomize_song();
      step(0, 0);
      step(0, 0);
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      end
      $display("[TB] random round %0d: go=%0d playing=%0b done=%0b", round, go, playing, done);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
